mac32_dot_seq: RTL
==================

Name: mac32_dot_seq

Overview:
- Sequencer that computes a floating-point dot product by time-multiplexing one combinational MAC32_top instance: acc = sum(A[k]*B[k]) + C_init.
- Accepts operand pairs over a valid/ready stream and drives the MAC's A_i/B_i/C_i from registers.
- Feeds Result_o back into an accumulator and returns one registered result per job.
- Sits between a job/operand source (stim_gen or future host) and MAC32_top.

Parameters:
- PARM_XLEN, 32, operand/result width (IEEE-754 single); passed through to the MAC.
- PARM_LEN_W, 8, width of the job-length field; max vector length 2^PARM_LEN_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  job start request; sampled only in IDLE
- len_i  in  PARM_LEN_W  number of operand pairs, sampled with start_i
- c_init_i  in  PARM_XLEN  initial accumulator value, sampled with start_i
- abort_i  in  1  cancel current job
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  sequencer can accept a pair
- a_i  in  PARM_XLEN  operand A
- b_i  in  PARM_XLEN  operand B
- mac_a_o  out  PARM_XLEN  to MAC A_i (registered)
- mac_b_o  out  PARM_XLEN  to MAC B_i (registered)
- mac_c_o  out  PARM_XLEN  to MAC C_i (accumulator register)
- mac_result_i  in  PARM_XLEN  from MAC Result_o
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  PARM_XLEN  final dot-product result, held until next done

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: state=IDLE; acc, a_r, b_r, result_o, remaining = 0; in_ready_o=0; done_o=0; busy_o=0.
- MAC drive: mac_a_o=a_r, mac_b_o=b_r, mac_c_o=acc. No combinational path from a_i/b_i to the MAC.
- IDLE:
  - start_i=1 with len_i!=0: acc<=c_init_i, remaining<=len_i, go to FETCH.
  - start_i=1 with len_i==0: result_o<=c_init_i, go to DONE.
  - start_i is ignored in every other state.
- FETCH:
  - in_ready_o=1 (combinational from state only, not from in_valid_i).
  - in_valid_i=1: a_r<=a_i, b_r<=b_i, go to EXEC.
  - Otherwise hold; stalls of any length are allowed.
- EXEC:
  - in_ready_o=0.
  - acc<=mac_result_i; remaining<=remaining-1.
  - remaining==1: result_o<=mac_result_i, go to DONE. Otherwise go to FETCH.
- DONE: done_o=1 for exactly this cycle, busy_o=1; go to IDLE. A start_i in this cycle is ignored.
- Timing: with in_valid_i held high and start at cycle 0, pairs are accepted at cycles 1,3,5,… and done_o is high at cycle 2N+1. Throughput is 1 pair per 2 cycles.
- abort_i:
  - In FETCH or EXEC: go to IDLE next cycle; acc and result_o are unchanged; no done_o.
  - In FETCH, a pair presented in the same cycle is not accepted: in_ready_o is forced to 0 when abort_i=1.
  - In IDLE or DONE: ignored.
- rst mid-job: all state returns to reset values next cycle; result_o is cleared.
- len_i=2^PARM_LEN_W-1 must run to completion. remaining never underflows.
- NaN/Inf/denormal handling belongs to the MAC. The sequencer passes values through bit-exactly.

Test Plan:
- Reset then start, len=2, c_init=0x00000000, pairs (0x3F800000,0x40400000), (0x40000000,0x40800000), in_valid always high -> done_o at cycle 5 after start, result_o=0x41300000 (11.0).
- Same vectors, c_init=0x3F800000 -> result_o=0x41400000 (12.0). busy_o high cycles 1–5. in_ready_o high only at cycles 1 and 3.
- len=0, c_init=0x40400000 -> done_o one cycle after start, result_o=0x40400000, in_ready_o never asserts.
- len=3 with in_valid_i low for 4 cycles before each pair (all pairs 0x3F000000 × 0x40000000, c_init=0) -> result_o=0x40400000 (3.0). No pair is lost or duplicated.
- Start len=3, abort_i in the second FETCH -> in_ready_o=0 that cycle, IDLE next cycle, no done_o, result_o retains the previous job value. A following len=1 job (0x40000000 × 0x40000000, c_init 0) gives 0x40800000.
- start_i pulsed while busy and in DONE -> ignored. rst asserted in EXEC -> all outputs 0 next cycle, no done_o.

Source files
------------

// File: rtl/mac32_dot_seq.sv
// Dot-product sequencer: time-multiplexes one combinational MAC to compute
// sum(A[k]*B[k]) + C_init over a valid/ready operand stream, one result per job.
module mac32_dot_seq #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  c_init_i,
  input  logic                  abort_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PARM_XLEN-1:0]  a_i,
  input  logic [PARM_XLEN-1:0]  b_i,
  output logic [PARM_XLEN-1:0]  mac_a_o,
  output logic [PARM_XLEN-1:0]  mac_b_o,
  output logic [PARM_XLEN-1:0]  mac_c_o,
  input  logic [PARM_XLEN-1:0]  mac_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [PARM_XLEN-1:0]  result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PARM_XLEN-1:0]  r_acc,       w_acc_next;
  logic [PARM_XLEN-1:0]  r_a,         w_a_next;
  logic [PARM_XLEN-1:0]  r_b,         w_b_next;
  logic [PARM_XLEN-1:0]  r_result,    w_result_next;
  logic [PARM_LEN_W-1:0] r_remaining, w_remaining_next;
  logic                  w_in_ready;

  // Abort masks ready so a pair offered in the abort cycle is never consumed.
  assign w_in_ready = (r_state == S_FETCH) && !abort_i;

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_result_next    = r_result;
    w_remaining_next = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            w_acc_next       = c_init_i;
            w_remaining_next = len_i;
            w_state_next     = S_FETCH;
          end else begin
            w_result_next = c_init_i;
            w_state_next  = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          w_state_next = S_IDLE;
        end else if (in_valid_i) begin
          w_a_next     = a_i;
          w_b_next     = b_i;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (abort_i) begin
          w_state_next = S_IDLE;
        end else begin
          w_acc_next       = mac_result_i;
          w_remaining_next = r_remaining - PARM_LEN_W'(1);
          if (r_remaining == PARM_LEN_W'(1)) begin
            w_result_next = mac_result_i;
            w_state_next  = S_DONE;
          end else begin
            w_state_next = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_remaining <= '0;
    end else begin
      r_acc       <= w_acc_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_result    <= w_result_next;
      r_remaining <= w_remaining_next;
    end
  end

  // MAC operands come only from registers, keeping a_i/b_i off the MAC path.
  assign mac_a_o    = r_a;
  assign mac_b_o    = r_b;
  assign mac_c_o    = r_acc;
  assign in_ready_o = w_in_ready;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign result_o   = r_result;

endmodule
